alu_seq_ctrl: RTL
=================

Name: alu_seq_ctrl

Overview:
Command-driven sequencer for the 8-bit add/sub/multiply datapath.
- Accepts one operation request (opcode plus two operands) over a valid/ready handshake.
- Registers the operands and executes the operation on one shared WIDTH-bit adder. Add and subtract take a single compute cycle; multiply is an iterative shift-add over WIDTH cycles.
- Presents the 16-bit result on a valid/ready output handshake.
- Sits between the command source (bus or test controller) and the result consumer, and replaces the free-running sel-muxed datapath with explicit sequencing.

Parameters:
WIDTH, 8, operand width; result width is 2*WIDTH; multiply runs WIDTH iterations.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  command valid.
in_ready  output  1  controller can accept a command.
in_op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 illegal.
in_a  input  WIDTH  operand A, unsigned.
in_b  input  WIDTH  operand B, unsigned.
res_valid  output  1  result valid.
res_ready  input  1  consumer accepts result.
res_data  output  2*WIDTH  result.
res_cout  output  1  add: carry out; sub: borrow (1 iff a<b); mul/illegal: 0.
res_err  output  1  1 iff the result came from an illegal opcode.
busy  output  1  1 in any state other than IDLE.
op_count  output  16  number of completed result handshakes; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (rst high at a rising edge):
  - State goes to IDLE; operand/product/counter registers are cleared.
  - res_valid=0, res_data=0, res_cout=0, res_err=0, busy=0, op_count=0.
  - Reset wins over every other event, including mid-multiply and a pending result.
- in_ready = (state==IDLE) && !rst. It is combinational and has no dependence on in_valid.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - On in_valid && in_ready, capture in_op, in_a and in_b.
  - Go to MUL with iter=0 and product accumulator cleared if op==10; otherwise go to EXEC.
- EXEC (one cycle):
  - add: res_data={0, a+b low WIDTH bits}, res_cout=carry.
  - sub: res_data={0, (a-b) mod 2^WIDTH}, res_cout=(a<b).
  - illegal: res_data=0, res_cout=0, res_err=1.
  - Then go to DONE.
- MUL:
  - Each cycle: if multiplier bit [iter] is set, add A (via the shared adder) into the upper half of the accumulator, then shift the {carry, accumulator} right by 1.
  - iter increments each cycle. After iteration WIDTH-1, load res_data with the 2*WIDTH unsigned product, set res_cout=0, and go to DONE.
- DONE:
  - res_valid=1. res_data, res_cout and res_err are held stable until the handshake.
  - On res_valid && res_ready: go to IDLE, op_count++, clear res_valid and res_err. res_data keeps its last value.
- Latency, counted in rising edges from the accept edge to the first edge where res_valid is sampled high:
  - add/sub/illegal: 2.
  - mul: WIDTH+1 (9 for WIDTH=8).
  - Return to IDLE costs 1 cycle after the result handshake, so there is no back-to-back overlap and peak throughput is one op per latency+1 cycles.
- in_valid while busy is ignored. No command is queued or dropped-with-flag; the source must hold it until in_ready.
- res_ready while res_valid=0 has no effect.
- Operands are captured at accept. Changes to in_a, in_b or in_op afterwards do not affect the operation in flight.
- Output registers are updated only on the transition into DONE. There are no combinational paths from inputs to res_*.

Test Plan:
- Reset then add, with res_ready=1: a=200, b=100, op=00 -> res_valid 2 edges after accept, res_data=0x002C, res_cout=1, res_err=0, op_count=1.
- Sub with borrow: a=5, b=7 -> res_data=0x00FE, res_cout=1. Then sub a=7, b=5 -> 0x0002, res_cout=0.
- Mul corners:
  - 255*255 -> 0xFE01, res_valid 9 edges after accept, busy=1 throughout.
  - 0*173 -> 0x0000.
  - 16*16 -> 0x0100.
- Backpressure: res_ready low for 5 cycles after res_valid -> res_data/res_valid stable, in_ready=0, a new in_valid is ignored. Raising res_ready completes the handshake, op_count increments once, and in_ready=1 on the next cycle.
- Illegal op 11 with a=0x12, b=0x34 -> res_data=0, res_err=1, latency 2. res_err returns to 0 after the handshake.
- Reset mid-multiply (rst high at iteration 4) -> next cycle is IDLE with all outputs 0 and op_count=0. A following mul of 3*4 returns 0x000C with correct latency.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Command-driven sequencer for the add/sub/mul datapath.
// One shared WIDTH-bit adder; multiply is iterative shift-add.
module alu_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               res_cout,
  output logic               res_err,
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [IW-1:0]      iter;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_ci;
  logic [WIDTH:0]   add_s;

  logic accept;
  logic hs;
  logic last;

  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign hs        = res_valid && res_ready;
  assign last      = (iter == IW'(WIDTH - 1));

  // Sub uses a + ~b + 1; carry out of that is the inverted borrow.
  always_comb begin
    add_x  = a_q;
    add_y  = b_q;
    add_ci = 1'b0;
    unique case (1'b1)
      (state == MUL): begin
        add_x = acc[2*WIDTH-1:WIDTH];
        add_y = b_q[iter] ? a_q : '0;
      end
      (op_q == 2'b01): begin
        add_y  = ~b_q;
        add_ci = 1'b1;
      end
      default: ;
    endcase
    add_s = {1'b0, add_x} + {1'b0, add_y}
          + {{WIDTH{1'b0}}, add_ci};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nx = (in_op == 2'b10) ? MUL : EXEC;
      end
      EXEC: state_nx = DONE;
      MUL:  if (last) state_nx = DONE;
      DONE: if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      iter     <= '0;
      res_data <= '0;
      res_cout <= 1'b0;
      res_err  <= 1'b0;
      op_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q <= in_op;
            a_q  <= in_a;
            b_q  <= in_b;
            acc  <= '0;
            iter <= '0;
          end
        end
        EXEC: begin
          res_err  <= (op_q == 2'b11);
          res_data <= op_q[1] ? '0 :
            {{WIDTH{1'b0}}, add_s[WIDTH-1:0]};
          res_cout <= (op_q == 2'b00) ? add_s[WIDTH] :
                      (op_q == 2'b01) ? ~add_s[WIDTH] :
                      1'b0;
        end
        MUL: begin
          // Shift {carry, acc} right; adder output lands in the top.
          acc  <= {add_s, acc[WIDTH-1:1]};
          iter <= iter + IW'(1);
          if (last) begin
            res_data <= {add_s, acc[WIDTH-1:1]};
            res_cout <= 1'b0;
            res_err  <= 1'b0;
          end
        end
        DONE: begin
          if (hs) begin
            op_count <= op_count + 16'd1;
            res_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
